layer_mac_scheduler: RTL and testbench

// - Time-multiplexed controller for one fully connected layer of the ECG network.
// - Sequences a single shared 16-bit multiply-accumulate over N_OUT neurons instead of one node instance per neuron.
// - Each neuron: N_IN products plus bias, then ReLU, then one result per output handshake.
// - Reads activations and weights/biases from external synchronous memories; sits between layer buffers.

---
 rtl/layer_mac_scheduler.sv | 112 +++++++++++
 tb/tb_layer_mac_scheduler.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_mac_scheduler.sv
// Time-multiplexed MAC controller for one fully connected layer: a single shared
// multiply-accumulate walks N_OUT neurons, each N_IN products plus bias, then ReLU.
module layer_mac_scheduler #(
    parameter int N_IN  = 15,
    parameter int N_OUT = 32,
    parameter int DW    = 16,
    parameter int AAW   = 4,
    parameter int WAW   = 9,
    parameter int OIW   = 5
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic [AAW-1:0] act_addr,
    input  logic [DW-1:0]  act_data,
    output logic [WAW-1:0] w_addr,
    input  logic [DW-1:0]  w_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [OIW-1:0] out_idx,
    output logic [DW-1:0]  out_data
);

    localparam int KW = $clog2(N_IN + 1);
    localparam logic [KW-1:0]  K_LAST = KW'(N_IN);
    localparam logic [OIW-1:0] N_LAST = OIW'(N_OUT - 1);

    typedef enum logic [2:0] {IDLE, RUN, DRAIN, WRITE, FIN} state_t;

    state_t         state, state_nxt;
    logic [KW-1:0]  k;
    logic [OIW-1:0] neuron;
    logic [WAW-1:0] w_ptr;
    logic [DW-1:0]  acc;
    logic [DW-1:0]  prod;
    logic           ret_valid;
    logic           ret_bias;

    assign prod = act_data * w_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (k == K_LAST) state_nxt = DRAIN;
            DRAIN:   state_nxt = WRITE;
            WRITE:   if (out_ready) state_nxt = (neuron == N_LAST) ? FIN : RUN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Weights for consecutive neurons are contiguous, so a free-running pointer
    // reproduces neuron*(N_IN+1)+k without a multiplier.
    always_ff @(posedge clk) begin
        if (reset) begin
            k         <= '0;
            neuron    <= '0;
            w_ptr     <= '0;
            acc       <= '0;
            ret_valid <= 1'b0;
            ret_bias  <= 1'b0;
        end else begin
            ret_valid <= (state == RUN);
            ret_bias  <= (state == RUN) && (k == K_LAST);
            if (ret_valid) begin
                acc <= acc + (ret_bias ? w_data : prod);
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        k      <= '0;
                        neuron <= '0;
                        w_ptr  <= '0;
                        acc    <= '0;
                    end
                end
                RUN: begin
                    k     <= k + 1'b1;
                    w_ptr <= w_ptr + 1'b1;
                end
                WRITE: begin
                    if (out_ready && neuron != N_LAST) begin
                        neuron <= neuron + 1'b1;
                        k      <= '0;
                        acc    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign done      = (state == FIN);
    assign out_valid = (state == WRITE);
    assign out_idx   = neuron;
    assign out_data  = (out_valid && !acc[DW-1]) ? acc : '0;
    assign act_addr  = (state == RUN && k != K_LAST) ? AAW'(k) : '0;
    assign w_addr    = (state == RUN) ? w_ptr : '0;

endmodule

// File: tb/tb_layer_mac_scheduler.sv
// Scoreboard bench: a small (3x2) instance for directed vectors and a default
// instance for address sequence and throughput.
module tb_layer_mac_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   cyc_cnt = 0;
    always @(posedge clk) cyc_cnt++;

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        int          idx;
        logic [15:0] data;
    } res_t;

    // ---------------- small instance: N_IN=3, N_OUT=2 ----------------
    logic        s_start, s_busy, s_done, s_out_valid, s_out_ready;
    logic [1:0]  s_act_addr;
    logic [2:0]  s_w_addr;
    logic [15:0] s_act_data, s_w_data, s_out_data;
    logic [0:0]  s_out_idx;
    logic [15:0] s_act_mem [0:3];
    logic [15:0] s_w_mem   [0:7];

    layer_mac_scheduler #(.N_IN(3), .N_OUT(2), .DW(16), .AAW(2), .WAW(3), .OIW(1)) u_small (
        .clk(clk), .reset(reset), .start(s_start), .busy(s_busy), .done(s_done),
        .act_addr(s_act_addr), .act_data(s_act_data), .w_addr(s_w_addr), .w_data(s_w_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_idx(s_out_idx), .out_data(s_out_data)
    );

    always @(posedge clk) begin
        s_act_data <= s_act_mem[s_act_addr];
        s_w_data   <= s_w_mem[s_w_addr];
    end

    // ---------------- default instance: N_IN=15, N_OUT=32 ----------------
    logic        d_start, d_busy, d_done, d_out_valid, d_out_ready;
    logic [3:0]  d_act_addr;
    logic [8:0]  d_w_addr;
    logic [15:0] d_act_data, d_w_data, d_out_data;
    logic [4:0]  d_out_idx;
    logic [15:0] d_act_mem [0:15];
    logic [15:0] d_w_mem   [0:511];

    layer_mac_scheduler #(.N_IN(15), .N_OUT(32), .DW(16), .AAW(4), .WAW(9), .OIW(5)) u_dflt (
        .clk(clk), .reset(reset), .start(d_start), .busy(d_busy), .done(d_done),
        .act_addr(d_act_addr), .act_data(d_act_data), .w_addr(d_w_addr), .w_data(d_w_data),
        .out_valid(d_out_valid), .out_ready(d_out_ready), .out_idx(d_out_idx), .out_data(d_out_data)
    );

    always @(posedge clk) begin
        d_act_data <= d_act_mem[d_act_addr];
        d_w_data   <= d_w_mem[d_w_addr];
    end

    // ---------------- scoreboards / monitors ----------------
    res_t s_q[$];
    res_t d_q[$];
    int   s_results = 0, d_results = 0;
    int   s_done_cnt = 0, d_done_cnt = 0;
    int   s_acc_cyc [0:1];
    int   d_acc_cyc [0:31];

    always @(negedge clk) begin
        res_t e;
        if (!reset) begin
            if (s_out_valid && s_out_ready) begin
                s_results++;
                s_acc_cyc[s_out_idx] = cyc_cnt;
                if (s_q.size() == 0) begin
                    check("s_unexpected_result", 32'(s_results), 32'(s_results - 1));
                end else begin
                    e = s_q.pop_front();
                    check("s_out_idx", 32'(s_out_idx), e.idx);
                    check("s_out_data", 32'(s_out_data), 32'(e.data));
                end
            end
            if (s_done) s_done_cnt++;
        end
    end

    always @(negedge clk) begin
        res_t e;
        if (!reset) begin
            if (d_out_valid && d_out_ready) begin
                d_results++;
                d_acc_cyc[d_out_idx] = cyc_cnt;
                if (d_q.size() == 0) begin
                    check("d_unexpected_result", 32'(d_results), 32'(d_results - 1));
                end else begin
                    e = d_q.pop_front();
                    check("d_out_idx", 32'(d_out_idx), e.idx);
                    check("d_out_data", 32'(d_out_data), 32'(e.data));
                end
            end
            if (d_done) d_done_cnt++;
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_s(input int idx, input logic [15:0] data);
        res_t e;
        e.idx = idx;
        e.data = data;
        s_q.push_back(e);
    endtask

    task automatic load_basic();
        s_act_mem = '{16'd1, 16'd2, 16'd3, 16'd0};
        s_w_mem   = '{16'd5, 16'hFFE3, 16'hFFF0, 16'd3, 16'd26, 16'd24, 16'd13, 16'd0};
    endtask

    task automatic start_s();
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
    endtask

    task automatic wait_s_done(input string name, output int done_cyc);
        int n;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (s_done) break;
        end
        done_cyc = cyc_cnt;
        check(name, 32'(s_done), 32'd1);
    endtask

    task automatic wait_s_valid(input string name, output int n);
        for (n = 1; n < 200; n++) begin
            @(negedge clk);
            if (s_out_valid) break;
        end
        check(name, 32'(s_out_valid), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main stimulus ----------------
    initial begin
        int   lat, dcyc, r0, dn0, err_st, err_w, err_a;
        logic [15:0] hold_data;
        logic [0:0]  hold_idx;
        logic [1:0]  hold_aa;
        logic [2:0]  hold_wa;

        reset = 1'b1;
        s_start = 1'b0; s_out_ready = 1'b1;
        d_start = 1'b0; d_out_ready = 1'b1;
        load_basic();
        for (int i = 0; i < 16; i++) d_act_mem[i] = (i < 15) ? 16'd1 : 16'd0;
        for (int i = 0; i < 512; i++) d_w_mem[i] = 16'd1;

        // reset state
        tick(); tick();
        @(negedge clk);
        check("rst_busy", 32'(s_busy), 0);
        check("rst_done", 32'(s_done), 0);
        check("rst_out_valid", 32'(s_out_valid), 0);
        check("rst_out_data", 32'(s_out_data), 0);
        check("rst_out_idx", 32'(s_out_idx), 0);
        check("rst_d_busy", 32'(d_busy), 0);
        tick();
        reset = 1'b0;
        tick();

        // basic pass with latency, throughput, done timing
        push_s(0, 16'd0);
        push_s(1, 16'd113);
        start_s();
        wait_s_valid("s_first_valid_timeout", lat);
        check("s_first_valid_latency", 32'(lat), 32'd6);
        wait_s_done("s_done_timeout", dcyc);
        check("s_throughput", 32'(s_acc_cyc[1] - s_acc_cyc[0]), 32'd6);
        check("s_done_after_accept", 32'(dcyc - s_acc_cyc[1]), 32'd1);
        @(negedge clk);
        check("s_done_one_cycle", 32'(s_done), 0);
        check("s_pass1_results", 32'(s_results), 32'd2);

        // backpressure
        tick();
        s_out_ready = 1'b0;
        push_s(0, 16'd0);
        push_s(1, 16'd113);
        r0 = s_results;
        start_s();
        wait_s_valid("s_bp_valid_timeout", lat);
        hold_data = s_out_data; hold_idx = s_out_idx;
        hold_aa = s_act_addr;   hold_wa = s_w_addr;
        err_st = 0;
        repeat (10) begin
            @(negedge clk);
            if (!s_out_valid || s_out_data !== hold_data || s_out_idx !== hold_idx ||
                s_act_addr !== hold_aa || s_w_addr !== hold_wa) err_st++;
        end
        check("s_stall_stable", 32'(err_st), 0);
        check("s_stall_no_result", 32'(s_results - r0), 0);
        @(posedge clk); #1;
        s_out_ready = 1'b1;
        wait_s_done("s_bp_done_timeout", dcyc);
        check("s_bp_results", 32'(s_results - r0), 32'd2);

        // wrap-around arithmetic
        tick();
        s_act_mem = '{16'h4000, 16'h3000, 16'd0, 16'd0};
        s_w_mem   = '{16'd4, 16'd0, 16'd0, 16'd0, 16'd0, 16'd3, 16'd0, 16'd0};
        push_s(0, 16'd0);
        push_s(1, 16'd0);
        start_s();
        wait_s_done("s_wrap_done_timeout", dcyc);

        // start while busy and in FIN is ignored
        tick();
        load_basic();
        push_s(0, 16'd0);
        push_s(1, 16'd113);
        r0 = s_results; dn0 = s_done_cnt;
        start_s();
        repeat (3) tick();
        start_s();
        wait_s_done("s_busy_done_timeout", dcyc);
        s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        @(negedge clk);
        check("s_start_in_fin_ignored", 32'(s_busy), 0);
        repeat (5) tick();
        check("s_single_done", 32'(s_done_cnt - dn0), 32'd1);
        check("s_busy_results", 32'(s_results - r0), 32'd2);

        // reset during neuron 1 RUN
        push_s(0, 16'd0);
        r0 = s_results; dn0 = s_done_cnt;
        start_s();
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (s_busy && !s_out_valid && s_out_idx == 1'b1) break;
        end
        check("s_reached_neuron1", 32'(s_out_idx), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("s_reset_idle", 32'(s_busy), 0);
        check("s_reset_out_valid", 32'(s_out_valid), 0);
        repeat (10) tick();
        check("s_reset_no_done", 32'(s_done_cnt - dn0), 0);
        check("s_reset_results", 32'(s_results - r0), 32'd1);

        // fresh start after abandoned pass
        push_s(0, 16'd0);
        push_s(1, 16'd113);
        r0 = s_results;
        start_s();
        wait_s_done("s_fresh_done_timeout", dcyc);
        check("s_fresh_results", 32'(s_results - r0), 32'd2);
        check("s_queue_empty", 32'(s_q.size()), 0);

        // default configuration: addresses and throughput
        tick();
        for (int i = 0; i < 32; i++) begin
            res_t e;
            e.idx = i;
            e.data = 16'd16;
            d_q.push_back(e);
        end
        d_start = 1'b1;
        tick();
        d_start = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            if (d_out_valid && d_out_idx == 5'd30) break;
        end
        check("d_reached_neuron30", 32'(d_out_idx), 32'd30);
        @(posedge clk);
        err_w = 0; err_a = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (d_w_addr !== 9'(496 + k)) err_w++;
            if (k < 15 && d_act_addr !== 4'(k)) err_a++;
        end
        check("d_n31_w_addr_seq", 32'(err_w), 0);
        check("d_n31_act_addr_seq", 32'(err_a), 0);
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (d_done) break;
        end
        check("d_done_seen", 32'(d_done), 32'd1);
        check("d_results", 32'(d_results), 32'd32);
        check("d_throughput_first", 32'(d_acc_cyc[1] - d_acc_cyc[0]), 32'd18);
        check("d_throughput_last", 32'(d_acc_cyc[31] - d_acc_cyc[30]), 32'd18);
        check("d_queue_empty", 32'(d_q.size()), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
